// File: rtl/video_frame_sampler.sv
// 2:1 horizontal/vertical RGB565 decimator feeding an internal synchronous FIFO drained by read requests.
// Optional SAMPLER_AVERAGE_EN: store the per-channel average of each even/odd pixel pair instead of the even pixel.
module video_frame_sampler #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned FIFO_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               vs_in,
  input  logic [15:0]        rgb565_in,
  input  logic               rd_valid,
  output logic [15:0]        rd_data,
  output logic               rd_data_valid,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_start,
  output logic               overflow
);

  localparam int unsigned AW    = FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = 16;

  logic [PW-1:0] col;
  logic [PW-1:0] line;
  logic          de_d;
  logic          vs_d;
  logic          vs_rise;
  logic          de_fall;
  logic          sample;
  logic          wr_req;
  logic [15:0]   wr_word;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [15:0]   mem [DEPTH];

  assign vs_rise = vs_in & ~vs_d;
  assign de_fall = de_d & ~de_in;
  assign sample  = de_in & ~vs_in & ~col[0] & ~line[0]
                 & (col < PW'(H_ACTIVE)) & (line < PW'(V_ACTIVE));

  // Pixel/line position tracking and sync edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d        <= 1'b0;
      vs_d        <= 1'b0;
      col         <= '0;
      line        <= '0;
      frame_start <= 1'b0;
    end else begin
      de_d        <= de_in;
      vs_d        <= vs_in;
      frame_start <= vs_rise;
      if (!de_in)
        col <= '0;
      else if (col != '1)
        col <= col + PW'(1);
      if (vs_rise)
        line <= '0;
      else if (de_fall && line != '1)
        line <= line + PW'(1);
    end
  end

`ifdef SAMPLER_AVERAGE_EN
  logic          pend;
  logic [15:0]   hold;
  logic [5:0]    r_sum;
  logic [6:0]    g_sum;
  logic [5:0]    b_sum;

  // Even pixel waits one clk for its odd partner; a lone even pixel is dropped when de falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      hold <= '0;
    end else begin
      pend <= sample;
      if (sample)
        hold <= rgb565_in;
    end
  end

  assign r_sum   = 6'(hold[15:11]) + 6'(rgb565_in[15:11]);
  assign g_sum   = 7'(hold[10:5])  + 7'(rgb565_in[10:5]);
  assign b_sum   = 6'(hold[4:0])   + 6'(rgb565_in[4:0]);
  assign wr_req  = pend & de_in & ~vs_in;
  assign wr_word = {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
`else
  assign wr_req  = sample;
  assign wr_word = rgb565_in;
`endif

  // Full/empty come from the pre-cycle state; a vsync edge cancels any pop
  assign wr_en = wr_req & ~fifo_full & ~vs_rise;
  assign rd_en = rd_valid & ~fifo_empty & ~vs_rise;

  always_comb begin
    count_nxt = fifo_count;
    if (vs_rise)
      count_nxt = '0;
    else
      count_nxt = fifo_count + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_word;
  end

  // FIFO pointers, occupancy, read port and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_empty    <= 1'b1;
      fifo_full     <= 1'b0;
      overflow      <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en)
        rd_data <= mem[rd_ptr];
      if (vs_rise) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + AW'(1);
        if (rd_en)
          rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CW'(DEPTH));
      if (vs_rise)
        overflow <= 1'b0;
      else if (wr_req && fifo_full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_frame_sampler.sv
// Bench for video_frame_sampler: directed phases plus random pixels/read requests against a queue model.
// Honours SAMPLER_AVERAGE_EN when defined for the whole build.
module tb_video_frame_sampler;

  localparam int H     = 1280;
  localparam int V     = 720;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [15:0] rgb565_in = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic [10:0] fifo_count;
  logic        frame_start;
  logic        overflow;

  video_frame_sampler dut (
    .clk(clk), .rst(rst), .de_in(de_in), .vs_in(vs_in), .rgb565_in(rgb565_in),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .frame_start(frame_start), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nasrt = 0;
  int nfail = 0;

  // Reference model state
  logic [15:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_rdv = 1'b0;
  logic [15:0] m_rd_data = '0;
  logic        m_fs = 1'b0;
  logic        m_vs_d = 1'b0;
  logic [15:0] m_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
    int r, g, bl;
    r  = (int'(a[15:11]) + int'(b[15:11])) / 2;
    g  = (int'(a[10:5])  + int'(b[10:5]))  / 2;
    bl = (int'(a[4:0])   + int'(b[4:0]))   / 2;
    return {5'(r), 6'(g), 5'(bl)};
  endfunction

  task automatic check_all();
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("rd_data_valid", 32'(rd_data_valid), 32'(m_rdv));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: x/y are the pixel's column and line within the current frame
  task automatic step(input bit de, input bit vs, input logic [15:0] pix, input bit rdv,
                      input int x, input int y);
    bit samp, full, empty, vrise;
    logic [15:0] val;
`ifdef SAMPLER_AVERAGE_EN
    samp = de && !vs && (x % 2 == 1) && (y % 2 == 0) && (x - 1 < H) && (y < V);
    val  = avg(m_prev, pix);
`else
    samp = de && !vs && (x % 2 == 0) && (y % 2 == 0) && (x < H) && (y < V);
    val  = pix;
`endif
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    vrise = vs && !m_vs_d;
    m_rdv = 1'b0;
    if (vrise) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rdv && !empty) begin
        m_rdv = 1'b1;
        m_rd_data = q.pop_front();
      end
      if (samp) begin
        if (full) m_ovf = 1'b1;
        else q.push_back(val);
      end
    end
    m_fs   = vrise;
    m_vs_d = vs;
    m_prev = pix;
    de_in = de; vs_in = vs; rgb565_in = pix; rd_valid = rdv;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic vsync(input int rdmode);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0, rdmode != 0, -1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, rdmode != 0, -1, 0);
  endtask

  // pixmode 0: values 1..n, 1: random. rdmode 0 none, 1 always, 2 random, 3 always with a 10-clk gap
  task automatic drive_line(input int n, input int y, input int pixmode, input int rdmode);
    logic [15:0] pix;
    bit rdv;
    for (int x = 0; x < n; x++) begin
      pix = (pixmode == 0) ? 16'(x + 1) : 16'($urandom);
      case (rdmode)
        1: rdv = 1'b1;
        2: rdv = 1'($urandom_range(0, 1));
        3: rdv = !(x >= 400 && x < 410);
        default: rdv = 1'b0;
      endcase
      step(1, 0, pix, rdv, x, y);
    end
    for (int i = 0; i < 6; i++)
      step(0, 0, 16'h0, rdmode == 1 || rdmode == 3 || (rdmode == 2 && $urandom_range(0, 1) == 1), -1, y);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 1'b1, -1, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_all();
    chk("reset_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Decimation of one line 1..1280
    vsync(0);
    drive_line(H, 0, 0, 0);
    chk("count_line0", 32'(fifo_count), 32'd640);
    drive_line(H, 1, 0, 0);
    chk("count_line1", 32'(fifo_count), 32'd640);
    drive_line(H, 2, 0, 0);
    chk("count_capped", 32'(fifo_count), 32'd1024);
    chk("full_capped", 32'(fifo_full), 32'd1);
    chk("overflow_set", 32'(overflow), 32'd1);
    drain(20);
    vsync(0);
    chk("count_flushed", 32'(fifo_count), 32'd0);
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Continuous read with a 10-clk gap, then empty reads
    drive_line(H, 0, 0, 3);
    drain(8);
    chk("drained_empty", 32'(fifo_empty), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 1'b1, -1, 0);
    chk("empty_read_valid", 32'(rd_data_valid), 32'd0);
    chk("empty_read_count", 32'(fifo_count), 32'd0);

`ifdef SAMPLER_AVERAGE_EN
    vsync(0);
    step(1, 0, 16'h0001, 0, 0, 0);
    step(1, 0, 16'h0002, 0, 1, 0);
    step(1, 0, 16'hF800, 0, 2, 0);
    step(1, 0, 16'h0000, 0, 3, 0);
    step(1, 0, 16'h1234, 0, 4, 0);
    step(0, 0, 16'h0000, 0, -1, 0);
    chk("avg_lone_dropped", 32'(fifo_count), 32'd2);
    step(0, 0, 16'h0, 1, -1, 0);
    chk("avg_pair0", 32'(rd_data), 32'h0001);
    step(0, 0, 16'h0, 1, -1, 0);
    chk("avg_pair1", 32'(rd_data), 32'h7800);
`endif

    // Random frames with random read pressure, including an over-long line
    for (int f = 0; f < 2; f++) begin
      vsync(2);
      for (int y = 0; y < 4; y++) drive_line((y == 2) ? H + 10 : H, y, 1, 2);
      drain(1100);
    end

    // Asynchronous reset mid-line
    vsync(0);
    for (int x = 0; x < 100; x++) step(1, 0, 16'($urandom), 1'($urandom_range(0, 1)), x, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_full", 32'(fifo_full), 32'd0);
    chk("arst_rdv", 32'(rd_data_valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_fs", 32'(frame_start), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    de_in = 1'b0; vs_in = 1'b0; rd_valid = 1'b0; rgb565_in = '0;
    q.delete();
    m_ovf = 1'b0; m_rdv = 1'b0; m_rd_data = '0; m_fs = 1'b0; m_vs_d = 1'b0; m_prev = '0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all();
    vsync(0);
    drive_line(H, 0, 1, 2);
    drain(700);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
